// File: rtl/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Round-robin arbiter sharing one simulation-memory port among
//            NumReq valid/ready requesters, with in-order response routing.
// Options  : TB_MEM_ARB_PERF_EN enables the per-requester grant counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter #(
  parameter int NumReq         = 2,
  parameter int AddrWidth      = 48,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0]                   req_write_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]  req_strb_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  input  logic [NumReq-1:0]                   rsp_ready_i,
  output logic [DataWidth-1:0]                rsp_rdata_o,
  output logic                                mem_req_valid_o,
  input  logic                                mem_req_ready_i,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic                                mem_write_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  output logic [DataWidth/8-1:0]              mem_strb_o,
  input  logic                                mem_rsp_valid_i,
  output logic                                mem_rsp_ready_o,
  input  logic [DataWidth-1:0]                mem_rsp_rdata_i,
  output logic [NumReq-1:0][31:0]             perf_grant_o,
  output logic                                err_o
);

  localparam int c_IDW = $clog2(NumReq);
  localparam int c_PW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int c_CW  = $clog2(MaxOutstanding + 1);
  localparam logic [c_CW-1:0] c_MAX      = c_CW'(MaxOutstanding);
  localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(MaxOutstanding - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e           r_state;
  logic [c_IDW-1:0] r_rr;
  logic [c_IDW-1:0] r_lock_idx;
  logic [c_CW-1:0]  r_cnt;
  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;
  logic [c_IDW-1:0] r_id_fifo [MaxOutstanding];
  logic             r_err;

  logic [c_IDW-1:0] w_grant;
  logic [c_IDW-1:0] w_head;
  logic             w_can_issue;
  logic             w_empty;
  logic             w_req_hs;
  logic             w_rsp_hs;

  function automatic logic [c_IDW-1:0] rr_add(input logic [c_IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return c_IDW'(s);
  endfunction

  function automatic logic [c_PW-1:0] ptr_next(input logic [c_PW-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Scan offsets high to low so the requester closest to r_rr wins.
  always_comb begin
    w_grant = r_rr;
    if (r_state == S_LOCKED) begin
      w_grant = r_lock_idx;
    end else begin
      for (int i = NumReq - 1; i >= 0; i--) begin
        if (req_valid_i[rr_add(r_rr, i)]) w_grant = rr_add(r_rr, i);
      end
    end
  end

  assign w_can_issue     = (r_cnt < c_MAX);
  assign mem_req_valid_o = w_can_issue & req_valid_i[w_grant];
  assign mem_addr_o      = req_addr_i[w_grant];
  assign mem_write_o     = req_write_i[w_grant];
  assign mem_wdata_o     = req_wdata_i[w_grant];
  assign mem_strb_o      = req_strb_i[w_grant];
  assign w_req_hs        = mem_req_valid_o & mem_req_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (w_can_issue) req_ready_o[w_grant] = mem_req_ready_i;
  end

  assign w_empty = (r_cnt == '0);
  assign w_head  = r_id_fifo[r_rptr];

  always_comb begin
    rsp_valid_o = '0;
    if (!w_empty) rsp_valid_o[w_head] = mem_rsp_valid_i;
  end

  assign mem_rsp_ready_o = !w_empty & rsp_ready_i[w_head];
  assign rsp_rdata_o     = mem_rsp_rdata_i;
  assign w_rsp_hs        = mem_rsp_valid_i & mem_rsp_ready_o;
  assign err_o           = r_err;

  always_ff @(posedge clk_i) begin
    if (w_req_hs) r_id_fifo[r_wptr] <= w_grant;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_lock_idx <= '0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_wptr <= ptr_next(r_wptr);
        r_rr   <= rr_add(w_grant, 1);
      end
      if (w_rsp_hs) r_rptr <= ptr_next(r_rptr);
      case ({w_req_hs, w_rsp_hs})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      case (r_state)
        S_IDLE: begin
          if (mem_req_valid_o && !mem_req_ready_i) begin
            r_state    <= S_LOCKED;
            r_lock_idx <= w_grant;
          end
        end
        S_LOCKED: begin
          if (w_req_hs) begin
            r_state <= S_IDLE;
          end else if (!req_valid_i[r_lock_idx]) begin
            // Requester abandoned a stalled request.
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (mem_rsp_valid_i && w_empty) r_err <= 1'b1;
    end
  end

`ifdef TB_MEM_ARB_PERF_EN
  logic [31:0] r_perf [NumReq];
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_perf
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_perf[gi] <= '0;
      end else if (w_req_hs && (w_grant == c_IDW'(gi))) begin
        r_perf[gi] <= r_perf[gi] + 32'd1;
      end
    end
    assign perf_grant_o[gi] = r_perf[gi];
  end
`else
  assign perf_grant_o = '0;
`endif

endmodule

`default_nettype wire
